// File: rtl/alu_rr_arbiter_pkg.sv
// Shared definitions for the round-robin ALU arbiter: opcodes and FSM states.
package alu_rr_arbiter_pkg;

    // ALU opcodes as presented on reqX_op
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Requester index (round-robin pointer and operation owner)
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/alu_rr_arbiter_alu_core.sv
// Purely combinational shared ALU: ADD/SUB/AND/OR with zero flag, no state.
module alu_core
    import alu_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    // Operation select; arithmetic wraps modulo 2^WIDTH
    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            default: result_o = '0;
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for one shared, registered ALU stage.
// One operation in flight at a time: IDLE (grant) -> EXEC (compute) -> RESP.
module alu_rr_arbiter
    import alu_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp0_zero,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_result,
    output logic             resp1_zero,

    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    state_e           state_q, state_d;
    req_id_e          ptr_q, ptr_d;
    req_id_e          owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             grant0, grant1;
    logic             rdy0, rdy1;
    logic             rv0, rv1;
    logic             owner_ack;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_res),
        .zero_o   (alu_zero)
    );

    // Round-robin grant: a lone requester always wins, a tie goes to the pointer
    always_comb begin
        grant0 = req0_valid & (~req1_valid | (ptr_q == REQ0));
        grant1 = req1_valid & (~req0_valid | (ptr_q == REQ1));
    end

    // Next-state, operand capture, result capture and handshake decode
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_d     = res_q;
        zero_d    = zero_q;
        cnt_d     = cnt_q;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        rv0       = 1'b0;
        rv1       = 1'b0;
        owner_ack = (owner_q == REQ1) ? resp1_ready : resp0_ready;

        case (state_q)
            ST_IDLE: begin
                rdy0 = grant0;
                rdy1 = grant1;
                if (grant1) begin
                    owner_d = REQ1;
                    a_d     = req1_a;
                    b_d     = req1_b;
                    op_d    = req1_op;
                    state_d = ST_EXEC;
                end else if (grant0) begin
                    owner_d = REQ0;
                    a_d     = req0_a;
                    b_d     = req0_b;
                    op_d    = req0_op;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = alu_res;
                zero_d  = alu_zero;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rv0 = (owner_q == REQ0);
                rv1 = (owner_q == REQ1);
                // Only the owner's ready completes the operation; the
                // other requester's resp ready is ignored here.
                if (owner_ack) begin
                    cnt_d   = cnt_q + 1'b1;
                    ptr_d   = (owner_q == REQ0) ? REQ1 : REQ0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= REQ0;
            owner_q <= REQ0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced low while rst is high, even in the cycle rst is
    // first sampled; non-owner response outputs are held at zero.
    always_comb begin
        req0_ready   = rdy0 & ~rst;
        req1_ready   = rdy1 & ~rst;
        resp0_valid  = rv0 & ~rst;
        resp1_valid  = rv1 & ~rst;
        resp0_result = resp0_valid ? res_q : '0;
        resp1_result = resp1_valid ? res_q : '0;
        resp0_zero   = resp0_valid & zero_q;
        resp1_zero   = resp1_valid & zero_q;
        busy         = (state_q != ST_IDLE) & ~rst;
        ops_done     = rst ? '0 : cnt_q;
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed + randomized bench for alu_rr_arbiter with a transaction-level model.
module tb_alu_rr_arbiter;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_zero;
    logic             req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_zero;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, resp0_result, resp1_result;
    logic [1:0]       req0_op, req1_op;
    logic             busy;
    logic [CNT_W-1:0] ops_done;

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;   // model: which requester wins a tie
    int m_cnt    = 0;   // model: completed responses

    alu_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op), .resp0_valid(resp0_valid),
        .resp0_ready(resp0_ready), .resp0_result(resp0_result), .resp0_zero(resp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op), .resp1_valid(resp1_valid),
        .resp1_ready(resp1_ready), .resp1_result(resp1_result), .resp1_zero(resp1_zero),
        .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] a, b, input logic [1:0] op);
        int r;
        case (op)
            2'd0: r = int'(a) + int'(b);
            2'd1: r = int'(a) - int'(b) + (1 << WIDTH);
            2'd2: r = int'(a & b);
            default: r = int'(a | b);
        endcase
        return WIDTH'(r % (1 << WIDTH));
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rv0"}, resp0_valid, 0);
        chk({tag, "_rv1"}, resp1_valid, 0);
        chk({tag, "_res0"}, resp0_result, 0);
        chk({tag, "_res1"}, resp1_result, 0);
    endtask

    // One complete operation. hold = cycles the owner withholds resp ready;
    // keep = raise both valids while busy to show nothing else gets in.
    task automatic run_op(input bit v0, v1,
                          input logic [WIDTH-1:0] a0, b0, input logic [1:0] o0,
                          input logic [WIDTH-1:0] a1, b1, input logic [1:0] o1,
                          input int hold, input bit keep);
        int w;
        logic [WIDTH-1:0] er;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
        resp0_ready = 0; resp1_ready = 0;
        #1;
        w  = (v0 && v1) ? m_ptr : (v1 ? 1 : 0);
        er = (w == 1) ? ref_alu(a1, b1, o1) : ref_alu(a0, b0, o0);
        chk("grant_rdy0", req0_ready, w == 0);
        chk("grant_rdy1", req1_ready, w == 1);
        chk("grant_busy", busy, 0);
        @(negedge clk);
        req0_valid = keep; req1_valid = keep;
        req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_op = 2'($urandom);
        req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_op = 2'($urandom);
        #1;
        chk("exec_busy", busy, 1);
        chk("exec_rdy", {req0_ready, req1_ready}, 0);
        chk("exec_rv", {resp0_valid, resp1_valid}, 0);
        @(negedge clk); #1;
        for (int h = 0; h <= hold; h++) begin
            chk("resp_rv0", resp0_valid, w == 0);
            chk("resp_rv1", resp1_valid, w == 1);
            chk("resp_res0", resp0_result, (w == 0) ? er : '0);
            chk("resp_res1", resp1_result, (w == 1) ? er : '0);
            chk("resp_z0", resp0_zero, (w == 0) && (er == 0));
            chk("resp_z1", resp1_zero, (w == 1) && (er == 0));
            chk("resp_rdy", {req0_ready, req1_ready}, 0);
            chk("resp_busy", busy, 1);
            if (h < hold) begin
                resp0_ready = (w == 1); resp1_ready = (w == 0);
                @(negedge clk); #1;
            end
        end
        resp0_ready = (w == 0); resp1_ready = (w == 1);
        @(negedge clk);
        resp0_ready = 0; resp1_ready = 0; req0_valid = 0; req1_valid = 0;
        #1;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_ptr = 1 - w;
        chk("done_cnt", ops_done, m_cnt);
        chk_idle_outputs("done");
    endtask

    initial begin
        rst = 1; req0_valid = 1; req1_valid = 1;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        resp0_ready = 1; resp1_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdy", {req0_ready, req1_ready}, 0);
        chk("rst_cnt", ops_done, 0);
        chk_idle_outputs("rst");
        @(negedge clk);
        rst = 0; resp0_ready = 0; resp1_ready = 0;
        #1;
        chk("post_rst_rdy0", req0_ready, 1);
        chk("post_rst_rdy1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;

        // valid pulse that drops before the edge must not be latched
        @(negedge clk);
        req0_valid = 1; #2;
        chk("pulse_rdy0", req0_ready, 1);
        req0_valid = 0;
        @(negedge clk); #1;
        chk_idle_outputs("pulse");

        // directed cases
        run_op(1, 0, 4'b0101, 4'b0011, 2'b00, 0, 0, 0, 0, 0);
        run_op(1, 1, 4'b0011, 4'b0011, 2'b01, 4'b1100, 4'b1010, 2'b10, 0, 0);
        run_op(1, 1, 4'b0011, 4'b0011, 2'b01, 4'b1100, 4'b1010, 2'b10, 0, 0);
        run_op(0, 1, 0, 0, 0, 4'b1111, 4'b0000, 2'b11, 5, 1);
        chk("wrap_cnt", ops_done, 0);

        // reset during EXEC discards the operation
        @(negedge clk);
        req0_valid = 1; req0_a = 4'b0001; req0_b = 4'b0001; req0_op = 2'b00;
        @(negedge clk);
        req0_valid = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        m_cnt = 0; m_ptr = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rstx_cnt", ops_done, 0);
            chk_idle_outputs("rstx");
            @(negedge clk);
        end
        run_op(0, 1, 0, 0, 0, 4'b0110, 4'b0111, 2'b01, 1, 0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            bit rv0, rv1;
            rv0 = 1'($urandom); rv1 = 1'($urandom);
            if (!rv0 && !rv1) rv0 = 1;
            run_op(rv0, rv1, WIDTH'($urandom), WIDTH'($urandom), 2'($urandom),
                   WIDTH'($urandom), WIDTH'($urandom), 2'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
